// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the iterative multiply/divide unit.
// Handshake: the core raises start with funct3/Data1/Data2; the unit accepts it only
// in a cycle where busy is low. busy then stays high until the done cycle
// (inclusive). done is a one-cycle pulse and result/illegal are valid with it.
// result and illegal keep their values until the next accepted request.
// dbg_state mirrors the unit's FSM state so checkers can observe it.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] Data1;
    logic [XLEN-1:0] Data2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic [1:0]      dbg_state;

    modport master (
        output start, funct3, Data1, Data2,
        input  busy, done, result, illegal, dbg_state
    );

    modport slave (
        input  start, funct3, Data1, Data2,
        output busy, done, result, illegal, dbg_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per clock.
// Signed ops work on operand magnitudes; the sign is applied when the result is written.
// Build option: define MULDIV_DIV_EN to include the divider datapath and the
// divide special cases. Without it, divide ops finish right away with result 0 and illegal=1.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] hi_q, hi_d;       // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // multiplier bits / dividend-then-quotient
    logic [XLEN-1:0] opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic            sign_a, sign_b, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, mul_res, div_res, final_res;
    logic [2*XLEN-1:0] prod, prod_s;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] div_hi_n, div_lo_n, rem_s, quo_s;
    logic            div_zero, div_ovf;
`endif

    // Operand decode at accept time: signedness, magnitudes and divide special cases.
    always_comb begin
        sign_a = bus.Data1[XLEN-1] & ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110));
        sign_b = bus.Data2[XLEN-1] & ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                                      (bus.funct3 == 3'b110));
        mag_a  = sign_a ? (~bus.Data1 + 1'b1) : bus.Data1;
        mag_b  = sign_b ? (~bus.Data2 + 1'b1) : bus.Data2;
`ifdef MULDIV_DIV_EN
        div_zero = (bus.Data2 == '0);
        div_ovf  = !bus.funct3[0] && (bus.Data1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.Data2);
        special  = bus.funct3[2] && (div_zero || div_ovf);
        if (div_zero)
            spec_res = bus.funct3[1] ? bus.Data1 : '1;
        else
            spec_res = bus.funct3[1] ? '0 : bus.Data1;
`else
        special  = bus.funct3[2];
        spec_res = '0;
`endif
    end

    // One iteration step for each datapath plus the signed final result.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        prod     = {mul_hi_n, mul_lo_n};
        prod_s   = neg_q ? (~prod + 1'b1) : prod;
        mul_res  = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (!div_diff[XLEN]) begin
            div_hi_n = div_diff[XLEN-1:0];
            div_lo_n = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            div_hi_n = div_shift[XLEN-1:0];
            div_lo_n = {lo_q[XLEN-2:0], 1'b0};
        end
        rem_s   = neg_q ? (~div_hi_n + 1'b1) : div_hi_n;
        quo_s   = neg_q ? (~div_lo_n + 1'b1) : div_lo_n;
        div_res = op_q[1] ? rem_s : quo_s;
`else
        div_res = '0;
`endif
        final_res = op_q[2] ? div_res : mul_res;
    end

    // Next-state logic: accept, iterate XLEN steps, publish result, return to idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.funct3;
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                    // Remainder takes the dividend sign; everything else the xor of signs.
                    neg_d     = (bus.funct3[2] && bus.funct3[1]) ? sign_a : (sign_a ^ sign_b);
                    if (special) begin
                        state_d  = S_DONE;
                        result_d = spec_res;
`ifndef MULDIV_DIV_EN
                        illegal_d = 1'b1;
`endif
                    end else begin
                        state_d = S_CALC;
                        hi_d    = '0;
                        lo_d    = mag_a;
                        opb_d   = mag_b;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_DIV_EN
                if (op_q[2]) begin
                    hi_d = div_hi_n;
                    lo_d = div_lo_n;
                end else begin
                    hi_d = mul_hi_n;
                    lo_d = mul_lo_n;
                end
`else
                hi_d = mul_hi_n;
                lo_d = mul_lo_n;
`endif
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset mid-operation aborts silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
    assign bus.dbg_state = state_q;

endmodule
